complete_queue: RTL and testbench

- Buffered, parametrised complete stage between the EX units and the ROB.
- Accepts up to N_IN completion lanes per cycle and compacts them in lane order into a circular queue.
- Drains up to N_OUT oldest entries per cycle as ROB update lanes.
- Adds registered buffering, backpressure in both directions, and a branch-recovery flush.

---
 rtl/complete_queue.sv | 129 ++++++++++++
 tb/tb_complete_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_queue.sv
// complete_queue: buffered completion stage between the EX units and the ROB.
// Up to N_IN completion lanes per cycle are compacted in lane order into a
// circular queue. Up to N_OUT of the oldest entries drain per cycle as ROB
// update lanes. Upstream backpressure (ex_stall) depends only on registered
// occupancy. A flush (or reset) discards every queued entry.
module complete_queue #(
    parameter int N_IN      = 2,
    parameter int N_OUT     = 2,
    parameter int DEPTH     = 8,
    parameter int ROB_IDX_W = 6,
    parameter int ADDR_W    = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_IN-1:0]                    ex_valid,
    input  logic [N_IN-1:0][ROB_IDX_W-1:0]     ex_rob_idx,
    input  logic [N_IN-1:0]                    ex_branch_valid,
    input  logic [N_IN-1:0]                    ex_branch_taken,
    input  logic [N_IN-1:0][ADDR_W-1:0]        ex_branch_target,
    output logic                               ex_stall,
    input  logic                               rob_stall,
    input  logic                               flush,
    output logic [N_OUT-1:0]                   upd_valid,
    output logic [N_OUT-1:0][ROB_IDX_W-1:0]    upd_idx,
    output logic [N_OUT-1:0]                   upd_branch_taken,
    output logic [N_OUT-1:0][ADDR_W-1:0]       upd_branch_targets,
    output logic [$clog2(DEPTH):0]             occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage (data only, never reset)
    logic [ROB_IDX_W-1:0] r_idx    [DEPTH];
    logic                 r_taken  [DEPTH];
    logic [ADDR_W-1:0]    r_target [DEPTH];

    // Control state
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq_en;
    logic             w_deq_ok;
    logic [CNT_W-1:0] w_enq_n;
    logic [CNT_W-1:0] w_deq_n;
    logic [PTR_W-1:0] w_wr_ptr [N_IN];

    // Conservative stall: only registered occupancy is considered, so a
    // dequeue in this same cycle never unblocks the upstream lanes.
    assign ex_stall  = ({1'b0, r_count} + (CNT_W+1)'(N_IN)) > (CNT_W+1)'(DEPTH);
    assign occupancy = r_count;

    // Flush and reset both win over enqueue and dequeue.
    assign w_enq_en = reset & ~flush & ~ex_stall;
    assign w_deq_ok = reset & ~flush & ~rob_stall;

    // Compaction: each valid lane goes to tail plus the number of valid lanes below it.
    always_comb begin : enq_ctrl
        logic [CNT_W-1:0] w_ofs;
        w_ofs = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_wr_ptr[i] = r_tail + w_ofs[PTR_W-1:0];
            if (ex_valid[i]) begin
                w_ofs = w_ofs + CNT_W'(1);
            end
        end
        w_enq_n = w_enq_en ? w_ofs : '0;
    end

    // Dequeue count: as many of the oldest entries as lanes allow.
    always_comb begin
        w_deq_n = '0;
        if (w_deq_ok) begin
            w_deq_n = (r_count < CNT_W'(N_OUT)) ? r_count : CNT_W'(N_OUT);
        end
    end

    // Update lanes: show entry head+j when present, else drive zeros.
    always_comb begin : upd_drive
        logic [PTR_W-1:0] w_rd_ptr;
        upd_valid          = '0;
        upd_idx            = '0;
        upd_branch_taken   = '0;
        upd_branch_targets = '0;
        w_rd_ptr           = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_rd_ptr = r_head + PTR_W'(j);
            if (w_deq_ok && (CNT_W'(j) < r_count)) begin
                upd_valid[j]          = 1'b1;
                upd_idx[j]            = r_idx[w_rd_ptr];
                upd_branch_taken[j]   = r_taken[w_rd_ptr];
                upd_branch_targets[j] = r_target[w_rd_ptr];
            end
        end
    end

    // Pointer and count update; reset and flush clear the queue.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq_n[PTR_W-1:0];
            r_tail  <= r_tail + w_enq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    // Entry write with sanitising: non-branch completions store taken=0, target=0.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_IN; i++) begin
            if (w_enq_en && ex_valid[i]) begin
                r_idx[w_wr_ptr[i]]    <= ex_rob_idx[i];
                r_taken[w_wr_ptr[i]]  <= ex_branch_valid[i] & ex_branch_taken[i];
                r_target[w_wr_ptr[i]] <= ex_branch_valid[i] ? ex_branch_target[i] : '0;
            end
        end
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clock) disable iff (!reset)
        r_count <= CNT_W'(DEPTH));
    a_no_enq_stall: assert property (@(posedge clock) disable iff (!reset)
        ex_stall |-> (w_enq_n == '0));
`endif

endmodule

// File: tb/tb_complete_queue.sv
// Scoreboard bench for complete_queue (N_IN=3, N_OUT=2, DEPTH=8).
// Stimulus pushes expected ROB updates; a negedge monitor pops and compares.
module tb_complete_queue;

    logic                  clock;
    logic                  reset;
    logic [2:0]            ex_valid;
    logic [2:0][5:0]       ex_rob_idx;
    logic [2:0]            ex_branch_valid;
    logic [2:0]            ex_branch_taken;
    logic [2:0][31:0]      ex_branch_target;
    logic                  ex_stall;
    logic                  rob_stall;
    logic                  flush;
    logic [1:0]            upd_valid;
    logic [1:0][5:0]       upd_idx;
    logic [1:0]            upd_branch_taken;
    logic [1:0][31:0]      upd_branch_targets;
    logic [3:0]            occupancy;

    typedef struct packed {
        logic [5:0]  idx;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    logic mon_en  = 1'b0;

    complete_queue #(
        .N_IN(3), .N_OUT(2), .DEPTH(8), .ROB_IDX_W(6), .ADDR_W(32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .ex_valid           (ex_valid),
        .ex_rob_idx         (ex_rob_idx),
        .ex_branch_valid    (ex_branch_valid),
        .ex_branch_taken    (ex_branch_taken),
        .ex_branch_target   (ex_branch_target),
        .ex_stall           (ex_stall),
        .rob_stall          (rob_stall),
        .flush              (flush),
        .upd_valid          (upd_valid),
        .upd_idx            (upd_idx),
        .upd_branch_taken   (upd_branch_taken),
        .upd_branch_targets (upd_branch_targets),
        .occupancy          (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        ex_valid         = '0;
        ex_rob_idx       = '0;
        ex_branch_valid  = '0;
        ex_branch_taken  = '0;
        ex_branch_target = '0;
    endtask

    task automatic lane(input int l, input logic [5:0] idx, input logic bv,
                        input logic bt, input logic [31:0] tgt);
        ex_valid[l]         = 1'b1;
        ex_rob_idx[l]       = idx;
        ex_branch_valid[l]  = bv;
        ex_branch_taken[l]  = bt;
        ex_branch_target[l] = tgt;
    endtask

    task automatic exp_push(input logic [5:0] idx, input logic taken, input logic [31:0] tgt);
        exp_t e;
        e.idx   = idx;
        e.taken = taken;
        e.tgt   = tgt;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Monitor: every presented update must be the oldest expected entry.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int j = 0; j < 2; j++) begin
                if (upd_valid[j] === 1'b1) begin
                    if (sb.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_update lane %0d: got idx %0d, expected no update at %0t",
                                 j, upd_idx[j], $time);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("upd_idx",    64'(upd_idx[j]),            64'(mon_e.idx));
                        chk("upd_taken",  64'(upd_branch_taken[j]),   64'(mon_e.taken));
                        chk("upd_target", 64'(upd_branch_targets[j]), 64'(mon_e.tgt));
                    end
                end else begin
                    chk("upd_valid_known", 64'(upd_valid[j]),          64'(0));
                    chk("idle_idx",        64'(upd_idx[j]),            64'(0));
                    chk("idle_taken",      64'(upd_branch_taken[j]),   64'(0));
                    chk("idle_target",     64'(upd_branch_targets[j]), 64'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        rob_stall = 1'b0;
        flush     = 1'b0;
        clr();
        next_cycle();
        next_cycle();
        reset  = 1'b1;
        mon_en = 1'b1;
        sample();
        chk("rst_upd_valid", 64'(upd_valid), 64'(0));
        chk("rst_ex_stall",  64'(ex_stall),  64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        next_cycle();

        // Basic latency, non-branch lane is sanitised
        lane(0, 6'd42, 1'b0, 1'b1, 32'h500);
        exp_push(6'd42, 1'b0, 32'h0);
        sample();
        chk("lat_no_bypass", 64'(upd_valid), 64'(0));
        next_cycle();
        clr();
        sample();
        chk("lat_upd_valid", 64'(upd_valid), 64'(2'b01));
        chk("lat_occ1",      64'(occupancy), 64'(1));
        next_cycle();
        sample();
        chk("lat_occ0",      64'(occupancy), 64'(0));
        next_cycle();

        // Compaction: lanes 0 and 2 valid, lane 1 carries junk but is invalid
        lane(0, 6'd3, 1'b0, 1'b0, 32'h0);
        lane(2, 6'd19, 1'b1, 1'b1, 32'hABC);
        ex_rob_idx[1] = 6'd55;
        exp_push(6'd3, 1'b0, 32'h0);
        exp_push(6'd19, 1'b1, 32'hABC);
        next_cycle();
        clr();
        sample();
        chk("cmp_upd_valid", 64'(upd_valid),             64'(2'b11));
        chk("cmp_idx",       64'(upd_idx),               64'({6'd19, 6'd3}));
        chk("cmp_taken1",    64'(upd_branch_taken[1]),   64'(1));
        chk("cmp_target1",   64'(upd_branch_targets[1]), 64'(32'hABC));
        next_cycle();

        // Fill and stall
        rob_stall = 1'b1;
        lane(0, 6'd10, 1'b0, 1'b1, 32'h999);
        lane(1, 6'd11, 1'b1, 1'b0, 32'h111);
        lane(2, 6'd12, 1'b1, 1'b1, 32'h222);
        exp_push(6'd10, 1'b0, 32'h0);
        exp_push(6'd11, 1'b0, 32'h111);
        exp_push(6'd12, 1'b1, 32'h222);
        sample();
        chk("fill_upd_held", 64'(upd_valid), 64'(0));
        chk("fill_stall0",   64'(ex_stall),  64'(0));
        next_cycle();
        clr();
        lane(0, 6'd13, 1'b0, 1'b0, 32'h0);
        lane(1, 6'd14, 1'b0, 1'b0, 32'h0);
        lane(2, 6'd15, 1'b0, 1'b0, 32'h0);
        exp_push(6'd13, 1'b0, 32'h0);
        exp_push(6'd14, 1'b0, 32'h0);
        exp_push(6'd15, 1'b0, 32'h0);
        sample();
        chk("fill_stall3", 64'(ex_stall), 64'(0));
        next_cycle();
        clr();
        lane(0, 6'd60, 1'b0, 1'b0, 32'h0);
        lane(1, 6'd61, 1'b0, 1'b0, 32'h0);
        lane(2, 6'd62, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("full_stall",    64'(ex_stall),  64'(1));
            chk("full_occ",      64'(occupancy), 64'(6));
            chk("full_upd_held", 64'(upd_valid), 64'(0));
            next_cycle();
        end

        // Drain with wrap: idx 20 is held until the stall drops
        rob_stall = 1'b0;
        clr();
        lane(0, 6'd20, 1'b0, 1'b0, 32'h0);
        sample();
        chk("d1_occ",   64'(occupancy), 64'(6));
        chk("d1_stall", 64'(ex_stall),  64'(1));
        chk("d1_upd",   64'(upd_valid), 64'(2'b11));
        next_cycle();
        exp_push(6'd20, 1'b0, 32'h0);
        sample();
        chk("d2_occ",   64'(occupancy), 64'(4));
        chk("d2_stall", 64'(ex_stall),  64'(0));
        chk("d2_upd",   64'(upd_valid), 64'(2'b11));
        next_cycle();
        clr();
        lane(0, 6'd21, 1'b0, 1'b0, 32'h0);
        exp_push(6'd21, 1'b0, 32'h0);
        sample();
        chk("d3_occ", 64'(occupancy), 64'(3));
        chk("d3_upd", 64'(upd_valid), 64'(2'b11));
        next_cycle();
        clr();
        lane(0, 6'd22, 1'b0, 1'b0, 32'h0);
        exp_push(6'd22, 1'b0, 32'h0);
        sample();
        chk("d4_occ", 64'(occupancy), 64'(2));
        chk("d4_upd", 64'(upd_valid), 64'(2'b11));
        next_cycle();
        clr();
        lane(0, 6'd23, 1'b0, 1'b0, 32'h0);
        exp_push(6'd23, 1'b0, 32'h0);
        sample();
        chk("d5_occ", 64'(occupancy), 64'(1));
        chk("d5_upd", 64'(upd_valid), 64'(2'b01));
        next_cycle();
        clr();
        sample();
        chk("d6_occ", 64'(occupancy), 64'(1));
        chk("d6_upd", 64'(upd_valid), 64'(2'b01));
        next_cycle();
        sample();
        chk("d7_occ", 64'(occupancy), 64'(0));
        chk("d7_upd", 64'(upd_valid), 64'(0));
        next_cycle();

        // Flush with 5 entries queued and 3 lanes presented
        rob_stall = 1'b1;
        lane(0, 6'd30, 1'b0, 1'b0, 32'h0);
        lane(1, 6'd31, 1'b0, 1'b0, 32'h0);
        lane(2, 6'd32, 1'b0, 1'b0, 32'h0);
        exp_push(6'd30, 1'b0, 32'h0);
        exp_push(6'd31, 1'b0, 32'h0);
        exp_push(6'd32, 1'b0, 32'h0);
        next_cycle();
        clr();
        lane(0, 6'd33, 1'b0, 1'b0, 32'h0);
        lane(1, 6'd34, 1'b0, 1'b0, 32'h0);
        exp_push(6'd33, 1'b0, 32'h0);
        exp_push(6'd34, 1'b0, 32'h0);
        next_cycle();
        clr();
        rob_stall = 1'b0;
        flush     = 1'b1;
        lane(0, 6'd50, 1'b1, 1'b1, 32'h50);
        lane(1, 6'd51, 1'b0, 1'b0, 32'h0);
        lane(2, 6'd52, 1'b0, 1'b0, 32'h0);
        sample();
        chk("fl_occ5",  64'(occupancy), 64'(5));
        chk("fl_upd",   64'(upd_valid), 64'(0));
        chk("fl_stall", 64'(ex_stall),  64'(0));
        next_cycle();
        flush = 1'b0;
        clr();
        sb.delete();
        sample();
        chk("fl_occ0",      64'(occupancy), 64'(0));
        chk("fl_after_upd", 64'(upd_valid), 64'(0));
        next_cycle();
        sample();
        chk("fl_still_empty", 64'(occupancy), 64'(0));
        next_cycle();

        // Mid-run reset with entries queued
        rob_stall = 1'b1;
        lane(0, 6'd40, 1'b0, 1'b0, 32'h0);
        lane(1, 6'd41, 1'b0, 1'b0, 32'h0);
        next_cycle();
        clr();
        reset     = 1'b0;
        rob_stall = 1'b0;
        sb.delete();
        sample();
        chk("mr_occ_before", 64'(occupancy), 64'(2));
        next_cycle();
        reset = 1'b1;
        lane(0, 6'd7, 1'b0, 1'b0, 32'h0);
        exp_push(6'd7, 1'b0, 32'h0);
        sample();
        chk("mr_upd",    64'(upd_valid),          64'(0));
        chk("mr_occ",    64'(occupancy),          64'(0));
        chk("mr_stall",  64'(ex_stall),           64'(0));
        chk("mr_idx",    64'(upd_idx),            64'(0));
        chk("mr_target", 64'(upd_branch_targets), 64'(0));
        next_cycle();
        clr();
        sample();
        chk("mr_new_upd", 64'(upd_valid),  64'(2'b01));
        chk("mr_new_idx", 64'(upd_idx[0]), 64'(7));
        chk("mr_new_occ", 64'(occupancy),  64'(1));
        next_cycle();
        sample();
        chk("mr_end_occ", 64'(occupancy), 64'(0));
        next_cycle();
        next_cycle();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
